arbiter_weighted_rr: RTL

N-requester weighted round-robin arbiter, successor to the plain round-robin arbiter. Each grant is held for up to weight[i] accepted beats, counted on a downstream ack, before rotating to the next requester. Grants are registered and rotation is fair and starvation-free. It sits in front of shared resources (bus ports, memory banks) where some clients need a larger bandwidth share.

---
 rtl/arbiter_weighted_rr.sv | 118 +++++++++++
 1 files changed

// File: rtl/arbiter_weighted_rr.sv
// N-way weighted round-robin arbiter: the grant is held for up to weight[i] acked beats, then rotates.
// Latency req->grant is one cycle, and release re-arbitrates without a bubble. ack stalls the credit count only.
module arbiter_weighted_rr #(
  parameter int N        = 4,
  parameter int WEIGHT_W = 4,
  parameter int IDX_W    = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*WEIGHT_W-1:0] weight,
  input  logic                  ack,
  output logic [N-1:0]          grant,
  output logic [IDX_W-1:0]      grant_idx,
  output logic                  grant_valid,
  output logic [WEIGHT_W-1:0]   credit
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [N-1:0]          grant_q, grant_d;
  logic [WEIGHT_W-1:0]   credit_q, credit_d;

  logic [IDX_W-1:0]      idx_inc, arb_ptr, win_idx;
  logic                  win_vld, release_g, load;
  logic [WEIGHT_W-1:0]   wt_arr [N];
  logic [WEIGHT_W-1:0]   win_wt;

  always_comb begin
    idx_inc = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + 1'b1;
    // On release the scan must already start past the outgoing grantee.
    arb_ptr = (state_q == GRANT) ? idx_inc : ptr_q;
  end

  always_comb begin
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(arb_ptr) + k;
      if (j >= N) j = j - N;
      if (!win_vld && req[IDX_W'(j)]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) wt_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
    win_wt = (wt_arr[win_idx] == '0) ? WEIGHT_W'(1) : wt_arr[win_idx];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      grant_q  <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
    end
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    credit_d  = credit_q;
    release_g = 1'b0;
    load      = 1'b0;
    if (state_q == IDLE) begin
      load = win_vld;
    end else begin
      release_g = !req[idx_q] || (ack && credit_q == WEIGHT_W'(1));
      if (release_g) begin
        ptr_d = idx_inc;
        load  = win_vld;
        if (!win_vld) begin
          state_d  = IDLE;
          idx_d    = '0;
          grant_d  = '0;
          credit_d = '0;
        end
      end else if (ack) begin
        credit_d = credit_q - 1'b1;
      end
    end
    if (load) begin
      state_d          = GRANT;
      idx_d            = win_idx;
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
      credit_d         = win_wt;
    end
  end

  // Outputs
  always_comb begin
    grant       = grant_q;
    grant_idx   = idx_q;
    grant_valid = |grant_q;
    credit      = credit_q;
  end

endmodule
